grayscale_mmio_rd_rsp: RTL and testbench
========================================

// Module: grayscale_mmio_rd_rsp
// PURPOSE
//  MMIO read responder for the grayscale AFU: answers host CCI-P MMIO read requests (c0 Rx) on the c2 Tx channel.
//  Serves the AFU DFH, the AFU ID and the grayscale CSR set (control, DSM base, status, response counter).
//  Sits beside grayscale_csr, which owns writes. Its response port is OR-muxed into c2Tx with the MPF responder;
//  rsp_hold stalls this block while MPF owns c2. Requests are queued so none are lost while held.
// PARAMETERS
//  AFU_ID_L       64'h0             low 64 bits of AFU UUID (byte 0x008)
//  AFU_ID_H       64'h0             high 64 bits of AFU UUID (byte 0x010)
//  DFH_NEXT       24'h000400        DFH next-feature byte offset (MPF DFH location)
//  FIFO_DEPTH     4                 pending-request queue depth, power of 2, >=2
// PORTS
//  clk          in   1   CCI-P clock (pClk)
//  reset_n      in   1   async active-low reset
//  req_valid    in   1   MMIO read request strobe (one cycle per request)
//  req_addr     in   16  dword address (byte address = req_addr*4)
//  req_len      in   2   0 = 4-byte read, 1 = 8-byte read; 2,3 treated as 1
//  req_tid      in   9   transaction ID, echoed in response
//  ctrl_value   in   64  live hc_control CSR
//  dsm_base     in   64  live DSM base CSR
//  status       in   64  live status word
//  rsp_hold     in   1   c2 busy this cycle (MPF response); no pop allowed
//  rsp_valid    out  1   response strobe (maps to c2Tx.mmioRdValid)
//  rsp_tid      out  9   echoed tid
//  rsp_data     out  64  read data
//  ovf_err      out  1   sticky: request dropped because queue full
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_tid=0, rsp_data=0, ovf_err=0, queue empty, resp_cnt=0; applies immediately (async),
//   release synchronous to clk. Requests in flight at reset are discarded; no response emitted for them.
//  Enqueue: req_valid=1 at cycle T writes {addr,len,tid} into queue (entry visible at T+1).
//  Pop: at cycle P, if queue non-empty and rsp_hold=0, pop head, decode, register; rsp_valid=1 at P+1
//   for exactly one cycle. Min latency request->rsp_valid = 2 cycles. Max one response per cycle, FIFO order.
//  rsp_valid=0 in any cycle following a cycle with no pop.
//  Full queue: push+pop same cycle -> accepted (count unchanged). Full, no pop -> request dropped,
//   ovf_err=1 until reset. Empty queue with push -> pop no earlier than next cycle (no bypass).
//  Decode (byte address A = {req_addr[15:1],3'b000}, 64-bit register R):
//   0x000 DFH = {4'h1, 19'b0, 1'b0 (eol), DFH_NEXT, 16'h0000}
//   0x008 AFU_ID_L   0x010 AFU_ID_H   0x018/0x020 reserved -> 0
//   0x028 ctrl_value  0x030 dsm_base  0x038 status  0x040 resp_cnt
//   any other address -> 0 (still responds; never drop a read)
//  Width: len=1 -> rsp_data=R (req_addr[0] ignored). len=0 -> rsp_data={32'h0, req_addr[0] ? R[63:32] : R[31:0]}.
//  CSR inputs sampled at pop cycle P (not at enqueue).
//  resp_cnt: 64-bit, +1 per emitted response, wraps to 0; a read of 0x040 returns value before its own increment.
//  Queue pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
// TESTING
//  1 Reset, req addr=0x0000 len=1 tid=0x05 -> rsp_valid at T+2, tid=0x05, data={4'h1,19'b0,1'b0,24'h400,16'h0}.
//  2 AFU_ID_L=64'hA1B2C3D4_E5F60718; 4B reads addr=0x0002 then 0x0003 -> data 0xE5F60718, then 0xA1B2C3D4.
//  3 rsp_hold=1 for 10 cycles, 4 reqs tids 1..4 -> no rsp_valid while held; then tids 1,2,3,4 on consecutive cycles.
//  4 rsp_hold=1, 5 reqs (depth 4) -> ovf_err=1, only tids 1..4 answered after release; ovf_err stays 1.
//  5 Read 0x0010 (resp_cnt) after 3 prior responses -> data 3; unmapped addr 0x0100 -> data 0, tid echoed.
//  6 reset_n low with 2 queued reqs mid-hold -> outputs 0 immediately; after release no stale responses.

Source files
------------

// File: rtl/grayscale_mmio_rd_rsp.sv
// MMIO read responder for the grayscale AFU: queues CCI-P MMIO read requests,
// decodes DFH / AFU ID / CSR reads and returns one registered response per cycle.
module grayscale_mmio_rd_rsp #(
    parameter logic [63:0] AFU_ID_L   = 64'h0,
    parameter logic [63:0] AFU_ID_H   = 64'h0,
    parameter logic [23:0] DFH_NEXT   = 24'h000400,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [8:0]  req_tid,
    input  logic [63:0] ctrl_value,
    input  logic [63:0] dsm_base,
    input  logic [63:0] status,
    input  logic        rsp_hold,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        ovf_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [63:0] DFH   = {4'h1, 19'b0, 1'b0, DFH_NEXT, 16'h0000};

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  len;
        logic [8:0]  tid;
    } req_t;

    req_t             mem [FIFO_DEPTH];
    req_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [63:0]      resp_cnt;
    logic [63:0]      reg_val;
    logic [63:0]      rd_data;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop   = !empty && !rsp_hold;
    // A full queue still accepts a request when the head leaves in the same cycle.
    assign push  = req_valid && (!full || pop);
    assign drop  = req_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: req_addr, len: req_len, tid: req_tid};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode works on the 64-bit register index; the dword LSB only selects a half for 4-byte reads.
    always_comb begin
        head    = mem[rd_ptr];
        reg_val = '0;
        case (head.addr[15:1])
            15'd0:   reg_val = DFH;
            15'd1:   reg_val = AFU_ID_L;
            15'd2:   reg_val = AFU_ID_H;
            15'd5:   reg_val = ctrl_value;
            15'd6:   reg_val = dsm_base;
            15'd7:   reg_val = status;
            15'd8:   reg_val = resp_cnt;
            default: reg_val = '0;
        endcase
        if (head.len == 2'd0) begin
            rd_data = {32'h0, head.addr[0] ? reg_val[63:32] : reg_val[31:0]};
        end else begin
            rd_data = reg_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
            resp_cnt  <= '0;
            ovf_err   <= 1'b0;
        end else begin
            rsp_valid <= pop;
            if (pop) begin
                rsp_tid  <= head.tid;
                rsp_data <= rd_data;
                resp_cnt <= resp_cnt + 64'd1;
            end
            if (drop) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grayscale_mmio_rd_rsp.sv
// Directed bench for grayscale_mmio_rd_rsp: decode, latency, hold/queue,
// overflow and asynchronous reset behaviour against hand-computed values.
module tb_grayscale_mmio_rd_rsp;

    localparam logic [63:0] ID_L    = 64'hA1B2_C3D4_E5F6_0718;
    localparam logic [63:0] ID_H    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DFH_EXP = 64'h1000_0000_0400_0000;
    localparam logic [63:0] CTRL    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DSM     = 64'h5555_6666_7777_8888;
    localparam logic [63:0] STAT    = 64'hDEAD_BEEF_0000_0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic [1:0]  req_len;
    logic [8:0]  req_tid;
    logic [63:0] ctrl_value;
    logic [63:0] dsm_base;
    logic [63:0] status;
    logic        rsp_hold;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        ovf_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [63:0] n_rsp = '0;

    grayscale_mmio_rd_rsp #(
        .AFU_ID_L   (ID_L),
        .AFU_ID_H   (ID_H),
        .DFH_NEXT   (24'h000400),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_tid    (req_tid),
        .ctrl_value (ctrl_value),
        .dsm_base   (dsm_base),
        .status     (status),
        .rsp_hold   (rsp_hold),
        .rsp_valid  (rsp_valid),
        .rsp_tid    (rsp_tid),
        .rsp_data   (rsp_data),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single isolated read: no bypass, response exactly one cycle later, then idle.
    task automatic do_read(input string tag, input logic [15:0] a, input logic [1:0] l,
                           input logic [8:0] t, input logic [63:0] exp);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_tid   = t;
        step();
        req_valid = 1'b0;
        check({tag, "_nobypass"}, 64'(rsp_valid), 64'd0);
        step();
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_tid"}, 64'(rsp_tid), 64'(t));
        check({tag, "_data"}, rsp_data, exp);
        n_rsp++;
        step();
        check({tag, "_idle"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_tid    = '0;
        ctrl_value = CTRL;
        dsm_base   = DSM;
        status     = STAT;
        rsp_hold   = 1'b0;
        repeat (3) step();
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_tid", 64'(rsp_tid), 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_ovf", 64'(ovf_err), 64'd0);
        reset_n = 1'b1;
        step();

        do_read("dfh", 16'h0000, 2'd1, 9'h005, DFH_EXP);

        // back-to-back 4-byte reads of both AFU_ID_L halves
        req_valid = 1'b1; req_addr = 16'h0002; req_len = 2'd0; req_tid = 9'h011;
        step();
        req_addr = 16'h0003; req_tid = 9'h012;
        step();
        req_valid = 1'b0;
        check("idl_lo_valid", 64'(rsp_valid), 64'd1);
        check("idl_lo_tid", 64'(rsp_tid), 64'h011);
        check("idl_lo_data", rsp_data, 64'h0000_0000_E5F6_0718);
        step();
        check("idl_hi_valid", 64'(rsp_valid), 64'd1);
        check("idl_hi_tid", 64'(rsp_tid), 64'h012);
        check("idl_hi_data", rsp_data, 64'h0000_0000_A1B2_C3D4);
        n_rsp += 2;
        step();
        check("idl_idle", 64'(rsp_valid), 64'd0);

        do_read("idh_len2", 16'h0004, 2'd2, 9'h013, ID_H);
        do_read("ctrl_odd8", 16'h000B, 2'd1, 9'h014, CTRL);
        do_read("dsm_hi4", 16'h000D, 2'd0, 9'h015, 64'h0000_0000_5555_6666);
        do_read("status", 16'h000E, 2'd3, 9'h016, STAT);
        do_read("rsvd", 16'h0006, 2'd1, 9'h017, 64'd0);
        do_read("cnt", 16'h0010, 2'd1, 9'h018, n_rsp);
        do_read("unmapped", 16'h0100, 2'd1, 9'h1FF, 64'd0);

        // hold with four queued requests, then drain in order
        rsp_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1; req_addr = 16'h0000; req_len = 2'd1; req_tid = 9'(i);
            step();
            check("hold_enq_valid", 64'(rsp_valid), 64'd0);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("hold_valid", 64'(rsp_valid), 64'd0);
        end
        rsp_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_valid", 64'(rsp_valid), 64'd1);
            check("drain_tid", 64'(rsp_tid), 64'(i));
        end
        n_rsp += 4;
        step();
        check("drain_idle", 64'(rsp_valid), 64'd0);
        check("drain_ovf", 64'(ovf_err), 64'd0);

        // fifth request while held overflows the 4-deep queue
        rsp_hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            req_valid = 1'b1; req_addr = 16'h0002; req_len = 2'd0; req_tid = 9'(i);
            step();
            if (i == 4) check("ovf_pre", 64'(ovf_err), 64'd0);
        end
        req_valid = 1'b0;
        check("ovf_set", 64'(ovf_err), 64'd1);
        step();
        rsp_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("ovf_drain_valid", 64'(rsp_valid), 64'd1);
            check("ovf_drain_tid", 64'(rsp_tid), 64'(i));
            check("ovf_drain_data", rsp_data, 64'h0000_0000_E5F6_0718);
        end
        n_rsp += 4;
        step();
        check("ovf_no5_a", 64'(rsp_valid), 64'd0);
        step();
        check("ovf_no5_b", 64'(rsp_valid), 64'd0);
        check("ovf_sticky", 64'(ovf_err), 64'd1);

        do_read("cnt2", 16'h0010, 2'd1, 9'h1A0, n_rsp);

        // async reset with two requests queued under hold
        rsp_hold = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            req_valid = 1'b1; req_addr = 16'h0000; req_len = 2'd1; req_tid = 9'(i + 8);
            step();
        end
        req_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(rsp_valid), 64'd0);
        check("arst_tid", 64'(rsp_tid), 64'd0);
        check("arst_data", rsp_data, 64'd0);
        check("arst_ovf", 64'(ovf_err), 64'd0);
        step();
        reset_n  = 1'b1;
        rsp_hold = 1'b0;
        n_rsp    = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("arst_no_stale", 64'(rsp_valid), 64'd0);
        end
        do_read("cnt_after_rst", 16'h0010, 2'd1, 9'h055, 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
